mul32_seq: RTL
==============

# mul32_seq

Iterative 32x32 shift-and-add multiplier producing a 64-bit product for the datapath. Sits directly upstream of the datapath's 64-bit 2:1 result-select multiplexer: the product becomes one 64-bit candidate, and the mux picks between it and the other 64-bit result source. Uses a start/busy/done handshake; the product is held stable until the next accepted start.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is verified.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a multiply; sampled only in IDLE or DONE
- A  in  32  multiplicand, captured on the accepted start
- B  in  32  multiplier, captured on the accepted start
- signed_op  in  1  two's-complement operands when 1 (present only with MUL_SIGNED_EN)
- P  out  64  product; valid from the done cycle until the next accepted start
- busy  out  1  high while in CALC
- done  out  1  one-cycle pulse when P becomes valid

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1: accept the request.
  - Latch the multiplicand as A zero-extended to 64 bits and the multiplier as B.
  - Clear the accumulator and the 5-bit iteration counter.
  - Go to CALC.
- CALC, each cycle:
  - If multiplier[0]=1, accumulator += multiplicand (64-bit add, no carry-out kept).
  - Shift multiplicand left by 1 and multiplier right by 1.
  - Increment the counter.
  - After the iteration with counter=31, go to DONE and load P from the final accumulator (including that iteration's add).
- DONE: done=1 for this single cycle.
  - start=1: accepted exactly as in IDLE; next state is CALC.
  - start=0: go to IDLE.
- start while in CALC is ignored. It is not queued, and A/B changes are not observed.
- P changes only on the DONE-state load or on reset. On an accepted start, P holds the old product through CALC.
- No early termination: zero operands still take the full 32 iterations.

## Timing
- Reset values: state=IDLE, P=0, busy=0, done=0. The accumulator and counter are also cleared.
- Reset mid-CALC: abort; in the next cycle all outputs take their reset values and no done pulse is produced.
- Reset has priority over start in the same cycle.
- Latency: start accepted at edge 0 gives busy=1 in cycles 1..32, and done=1 with P valid in cycle 33. Busy and done are never high together.
- Back-to-back: start held high in the DONE cycle gives the next done 33 cycles later. Throughput is one product per 33 cycles.

## Configuration
- MUL_SIGNED_EN defined:
  - The signed_op port exists.
  - When signed_op=1 on the accepted start, A and B are replaced by their magnitudes. Magnitude of 0x80000000 is 2^31, which fits unsigned.
  - The sign flag (A[31]^B[31]) is latched on the accepted start.
  - When the flag is set, P is loaded with the two's-complement negation of the accumulator in DONE.
  - When signed_op=0, behaviour is unsigned. Latency is unchanged in both cases.
- MUL_SIGNED_EN undefined: no signed_op port; unsigned only; no negation logic.

## Structure
- Shared package mul_pkg holds:
  - the state enum (IDLE/CALC/DONE);
  - MUL_ITER = 32;
  - the counter width constant (5).
- One sub-module, mul_ctrl_fsm: state register, iteration counter, busy/done generation, and load/step/capture enables.
- The top level holds the shift registers, accumulator, sign handling and the P register.

## Test plan
- A=3, B=5, start pulse → busy in cycles 1..32, done in cycle 33, P=0x000000000000000F; P stays unchanged for 10 further cycles.
- A=0xFFFFFFFF, B=0xFFFFFFFF unsigned → P=0xFFFFFFFE00000001; A=0, B=0x12345678 → P=0, still after 33 cycles.
- With MUL_SIGNED_EN, signed_op=1:
  - A=0xFFFFFFFF, B=0xFFFFFFFF → P=1.
  - A=0x80000000, B=0x80000000 → P=0x4000000000000000.
  - A=0xFFFFFFFE, B=3 → P=0xFFFFFFFFFFFFFFFA.
- Start A=2, B=7; in cycle 10, pulse start with A=9, B=9 → exactly one done, in cycle 33, with P=14.
- Start A=2, B=7, then assert rst in cycle 15 → next cycle busy=0, done=0, P=0, and no done follows. A fresh start then completes normally.
- Back-to-back: start held high through the DONE cycle with A=6, B=7, after a first multiply of 2*3 → two done pulses 33 cycles apart, P=6 then P=42.

Source files
------------

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding and iteration constants for mul32_seq
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam int MUL_ITER  = 32;
    localparam int MUL_CNT_W = 5;

    // Counter value of the final iteration; that step also loads P.
    function automatic logic is_last_iter(input logic [MUL_CNT_W-1:0] cnt);
        return cnt == MUL_CNT_W'(MUL_ITER - 1);
    endfunction

endpackage

// File: rtl/mul_ctrl_fsm.sv
// rtl/mul_ctrl_fsm.sv - multiplier sequencer: state, iteration counter, handshake and datapath enables
module mul_ctrl_fsm
    import mul_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    output logic load_o,
    output logic step_o,
    output logic capture_o
);

    mul_state_e             state_q, state_d;
    logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;

    // Next-state, counter update and one-cycle enables for the datapath.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_o    = 1'b0;
        step_o    = 1'b0;
        capture_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load_o  = 1'b1;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // start is deliberately ignored here; nothing is queued.
                step_o = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (is_last_iter(cnt_q)) begin
                    capture_o = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (start_i) begin
                    load_o  = 1'b1;
                    cnt_d   = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers; reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == CALC);
    assign done_o = (state_q == DONE);

endmodule

// File: rtl/mul32_seq.sv
// rtl/mul32_seq.sv - iterative shift-and-add 32x32 multiplier; MUL_SIGNED_EN adds signed_op
module mul32_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef MUL_SIGNED_EN
    input  logic               signed_op,
`endif
    output logic [2*WIDTH-1:0] P,
    output logic               busy,
    output logic               done
);

    logic               load, step, capture;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplr_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] p_q;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] p_next;
`ifdef MUL_SIGNED_EN
    logic               neg_q;
    logic               neg_in;
`endif

    mul_ctrl_fsm u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .busy_o    (busy),
        .done_o    (done),
        .load_o    (load),
        .step_o    (step),
        .capture_o (capture)
    );

    // Operand conditioning: signed operands are reduced to magnitudes so the
    // core loop stays unsigned; the most negative value maps to 2^(WIDTH-1).
    always_comb begin
        a_mag = A;
        b_mag = B;
`ifdef MUL_SIGNED_EN
        neg_in = 1'b0;
        if (signed_op) begin
            if (A[WIDTH-1]) a_mag = '0 - A;
            if (B[WIDTH-1]) b_mag = '0 - B;
            neg_in = A[WIDTH-1] ^ B[WIDTH-1];
        end
`endif
    end

    // One partial product per cycle, plus the sign fix-up applied at capture.
    always_comb begin
        acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);
`ifdef MUL_SIGNED_EN
        p_next  = neg_q ? ('0 - acc_sum) : acc_sum;
`else
        p_next  = acc_sum;
`endif
    end

    // Shift registers and accumulator: loaded on accepted start, stepped in CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
`ifdef MUL_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else if (load) begin
            mcand_q <= {{WIDTH{1'b0}}, a_mag};
            mplr_q  <= b_mag;
            acc_q   <= '0;
`ifdef MUL_SIGNED_EN
            neg_q   <= neg_in;
`endif
        end else if (step) begin
            acc_q   <= acc_sum;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
        end
    end

    // Product register: holds the last result until the next completed multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else if (capture) begin
            p_q <= p_next;
        end
    end

    assign P = p_q;

endmodule
